// File: rtl/fetch_pkg.sv
// Shared encodings and defaults for the memory bus arbiter.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    XFER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IC   = 2'd1,
    DRD  = 2'd2,
    DWB  = 2'd3
  } owner_t;

  localparam int unsigned DEF_BEATS  = 4;
  localparam int unsigned DEF_STARVE = 2;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed priority dc_wb > dc_rd > ic, with the I-side forced to win once it
// has been starved for the configured number of D-side grants.
module mem_arb_prio
  import fetch_pkg::*;
(
  input  logic       ic_req,
  input  logic       dc_rd_req,
  input  logic       dc_wb_req,
  input  logic       starve_full,
  output logic [1:0] winner
);

  // Pick the next bus owner from the pending requests.
  always_comb begin
    winner = NONE;
    if (ic_req && starve_full) winner = IC;
    else if (dc_wb_req)        winner = DWB;
    else if (dc_rd_req)        winner = DRD;
    else if (ic_req)           winner = IC;
  end

endmodule

// File: rtl/mem_bus_arb.sv
// Arbitrates I-cache fills, D-cache fills and D-cache writebacks onto a single
// burst memory port: address phase until mem_ack, then BEATS data beats.
module mem_bus_arb
  import fetch_pkg::*;
#(
  parameter int unsigned BEATS  = DEF_BEATS,
  parameter int unsigned STARVE = DEF_STARVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_gnt,
  output logic        ic_data_v,
  output logic        ic_done,
  input  logic        dc_rd_req,
  input  logic [31:0] dc_rd_addr,
  output logic        dc_rd_gnt,
  output logic        dc_rd_data_v,
  output logic        dc_rd_done,
  input  logic        dc_wb_req,
  input  logic [31:0] dc_wb_addr,
  input  logic [31:0] dc_wb_data,
  output logic        dc_wb_gnt,
  output logic        dc_wb_pop,
  output logic        dc_wb_done,
  input  logic        flush,
  output logic [31:0] rd_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_beat,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  state_t        state;
  owner_t        owner;
  owner_t        winner;
  logic [1:0]    win_raw;
  logic [31:0]   win_addr;
  logic [31:0]   addr_q;
  logic          we_q;
  logic          req_q;
  logic [CW-1:0] beat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          starve_full;
  logic          suppress;
  logic          ic_flush;
  logic          ack_ev;
  logic          beat_ev;
  logic          last_ev;
  logic          ic_quiet;

  mem_arb_prio u_prio (
    .ic_req      (ic_req),
    .dc_rd_req   (dc_rd_req),
    .dc_wb_req   (dc_wb_req),
    .starve_full (starve_full),
    .winner      (win_raw)
  );

  // Decode arbitration result and the per-cycle transfer events.
  always_comb begin
    winner      = owner_t'(win_raw);
    starve_full = (starve_cnt == STARVE_MAX);
    case (winner)
      DWB:     win_addr = dc_wb_addr;
      DRD:     win_addr = dc_rd_addr;
      default: win_addr = ic_addr;
    endcase
    ic_flush = flush && (owner == IC);
    ack_ev   = (state == ADDR) && mem_ack;
    beat_ev  = (state == XFER) && mem_beat;
    last_ev  = beat_ev && (beat_cnt == LAST_BEAT);
    ic_quiet = suppress || flush;
  end

  // Transfer sequencing, owner/address capture and starvation tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= NONE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      suppress   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          suppress <= 1'b0;
          // A fetch that is already being redirected is not launched.
          if ((winner != NONE) && !(flush && (winner == IC))) begin
            state  <= ADDR;
            owner  <= winner;
            addr_q <= win_addr;
            we_q   <= (winner == DWB);
            req_q  <= 1'b1;
            if (winner == IC)
              starve_cnt <= '0;
            else if (ic_req && !starve_full)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ADDR: begin
          if (mem_ack) begin
            state    <= XFER;
            req_q    <= 1'b0;
            beat_cnt <= '0;
            if (ic_flush) suppress <= 1'b1;
          end else if (ic_flush) begin
            state <= IDLE;
            req_q <= 1'b0;
            owner <= NONE;
          end
        end
        XFER: begin
          if (ic_flush) suppress <= 1'b1;
          if (mem_beat) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= IDLE;
              owner    <= NONE;
              suppress <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Requester handshakes and memory-side drive.
  always_comb begin
    mem_req      = req_q;
    mem_we       = we_q;
    mem_addr     = addr_q;
    mem_wdata    = dc_wb_data;
    rd_data      = mem_rdata;
    ic_gnt       = ack_ev && (owner == IC);
    dc_rd_gnt    = ack_ev && (owner == DRD);
    dc_wb_gnt    = ack_ev && (owner == DWB);
    ic_data_v    = beat_ev && (owner == IC) && !ic_quiet;
    ic_done      = last_ev && (owner == IC) && !ic_quiet;
    dc_rd_data_v = beat_ev && (owner == DRD);
    dc_rd_done   = last_ev && (owner == DRD);
    dc_wb_pop    = beat_ev && (owner == DWB);
    dc_wb_done   = last_ev && (owner == DWB);
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb with a burst memory model and an event
// scoreboard (grants, beats, last beats) per requester.
module tb_mem_bus_arb;
  import fetch_pkg::*;

  localparam int unsigned BEATS  = 4;
  localparam int unsigned STARVE = 2;

  localparam logic [1:0] K_GNT  = 2'd0;
  localparam logic [1:0] K_BEAT = 2'd1;
  localparam logic [1:0] K_LAST = 2'd2;
  localparam logic [1:0] K_BAD  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  who;
    logic [31:0] val;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        ic_req, dc_rd_req, dc_wb_req, flush;
  logic [31:0] ic_addr, dc_rd_addr, dc_wb_addr, dc_wb_data;
  logic        ic_gnt, ic_data_v, ic_done;
  logic        dc_rd_gnt, dc_rd_data_v, dc_rd_done;
  logic        dc_wb_gnt, dc_wb_pop, dc_wb_done;
  logic [31:0] rd_data;
  logic        mem_req, mem_we, mem_ack, mem_beat;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  int   ack_delay, req_wait, beats_left, rd_rearm;
  int   ic_beats_seen, wb_pops_seen;
  bit   in_burst, noise, hold_beats, prev_last;
  logic [31:0] a;

  mem_bus_arb #(.BEATS(BEATS), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
    .ic_data_v(ic_data_v), .ic_done(ic_done),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_gnt(dc_rd_gnt),
    .dc_rd_data_v(dc_rd_data_v), .dc_rd_done(dc_rd_done),
    .dc_wb_req(dc_wb_req), .dc_wb_addr(dc_wb_addr), .dc_wb_data(dc_wb_data),
    .dc_wb_gnt(dc_wb_gnt), .dc_wb_pop(dc_wb_pop), .dc_wb_done(dc_wb_done),
    .flush(flush), .rd_data(rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_beat(mem_beat),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [1:0] who_of(input logic [2:0] v);
    if (v[2])      return IC;
    else if (v[1]) return DRD;
    else           return DWB;
  endfunction

  task automatic exp_xfer(input logic [1:0] who, input logic [31:0] addr,
                          input int nvis, input bit done_vis);
    ev_t e;
    e.kind = K_GNT; e.who = who; e.val = addr;
    exp_q.push_back(e);
    for (int i = 0; i < nvis; i++) begin
      e.kind = (done_vis && i == nvis - 1) ? K_LAST : K_BEAT;
      e.val  = '0;
      exp_q.push_back(e);
    end
  endtask

  // Memory-side drive for this cycle, then settle to the sampling point.
  task automatic pre();
    mem_ack = mem_req && !in_burst && (req_wait >= ack_delay);
    if (in_burst) mem_beat = !hold_beats && ($urandom_range(0, 3) != 0);
    else          mem_beat = noise && mem_req;
    mem_rdata  = $urandom();
    dc_wb_data = $urandom();
    #4;
  endtask

  // Observe, score, update requesters and the memory model, advance a cycle.
  task automatic post();
    logic [2:0] gv, dv, dn;
    ev_t ev, want;
    bit  have;
    gv = {ic_gnt, dc_rd_gnt, dc_wb_gnt};
    dv = {ic_data_v, dc_rd_data_v, dc_wb_pop};
    dn = {ic_done, dc_rd_done, dc_wb_done};
    chk("onehot", ($countones(gv) <= 1) && ($countones(dv) <= 1) && ($countones(dn) <= 1), 1);
    chk("req_in_burst", mem_req && in_burst, 0);
    if (prev_last) chk("bubble_req", mem_req, 0);
    prev_last = 0;
    have = 0;
    ev = '0;
    if (gv != 0) begin
      have = 1; ev.kind = K_GNT; ev.who = who_of(gv); ev.val = mem_addr;
      chk("mem_we", mem_we, (ev.who == DWB));
    end else if (dv != 0) begin
      have = 1; ev.who = who_of(dv); ev.val = '0;
      if (dn == dv)      ev.kind = K_LAST;
      else if (dn == 0)  ev.kind = K_BEAT;
      else               ev.kind = K_BAD;
      if (dv[2]) begin ic_beats_seen++; chk("ic_rdata", rd_data, mem_rdata); end
      if (dv[1]) chk("dc_rdata", rd_data, mem_rdata);
      if (dv[0]) begin wb_pops_seen++; chk("wb_wdata", mem_wdata, dc_wb_data); end
      if (ev.kind == K_LAST) prev_last = 1;
    end else if (dn != 0) begin
      have = 1; ev.kind = K_BAD; ev.who = who_of(dn); ev.val = '0;
    end
    if (have) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_event: observed %0h expected none", ev);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("event", ev, want);
      end
    end
    if (gv[2]) ic_req = 1'b0;
    if (gv[1]) dc_rd_req = 1'b0;
    if (gv[0]) dc_wb_req = 1'b0;
    if (dn[1] && rd_rearm > 0) begin dc_rd_req = 1'b1; rd_rearm--; end
    if (in_burst && mem_beat) begin
      beats_left--;
      if (beats_left == 0) in_burst = 0;
    end
    if (mem_ack) begin in_burst = 1; beats_left = BEATS; req_wait = 0; end
    else if (mem_req) req_wait++;
    else req_wait = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    pre();
    post();
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || in_burst || mem_req || ic_req || dc_rd_req || dc_wb_req) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, n < max, 1);
    repeat (3) tick();
    chk({tag, "_leftover"}, exp_q.size(), 0);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 20) begin tick(); n++; end
    chk(tag, mem_req, 1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    ic_req = 1'b0; dc_rd_req = 1'b0; dc_wb_req = 1'b0;
    ic_addr = 32'h0000_1100; dc_rd_addr = 32'h0000_2200; dc_wb_addr = 32'h0000_3300;
    dc_wb_data = '0; mem_ack = 1'b0; mem_beat = 1'b0; mem_rdata = '0;
    ack_delay = 0; req_wait = 0; beats_left = 0; rd_rearm = 0;
    ic_beats_seen = 0; wb_pops_seen = 0;
    in_burst = 0; noise = 0; hold_beats = 0; prev_last = 0;
    @(posedge clk); #1;
    tick();
    tick();
    pre();
    chk("rst_ctrl", {mem_req, mem_we, ic_gnt, ic_data_v, ic_done, dc_rd_gnt, dc_rd_data_v,
                     dc_rd_done, dc_wb_gnt, dc_wb_pop, dc_wb_done}, 0);
    chk("rst_addr", mem_addr, 0);
    post();
    rst = 1'b0;

    // All three request together: DWB, then DRD, then IC.
    dc_wb_req = 1'b1; dc_rd_req = 1'b1; ic_req = 1'b1;
    exp_xfer(DWB, dc_wb_addr, BEATS, 1);
    exp_xfer(DRD, dc_rd_addr, BEATS, 1);
    exp_xfer(IC,  ic_addr,    BEATS, 1);
    drain("prio_order", 300);

    // IC held while DRD keeps coming back: IC after exactly two DRD grants.
    for (int p = 0; p < 2; p++) begin
      ic_addr = 32'h0001_0000 + 32'(p) * 32'h40;
      dc_rd_addr = 32'h0002_0000 + 32'(p) * 32'h40;
      ic_req = 1'b1; dc_rd_req = 1'b1; rd_rearm = 2;
      exp_xfer(DRD, dc_rd_addr, BEATS, 1);
      exp_xfer(DRD, dc_rd_addr, BEATS, 1);
      exp_xfer(IC,  ic_addr,    BEATS, 1);
      exp_xfer(DRD, dc_rd_addr, BEATS, 1);
      drain("starve", 400);
    end

    // Slow ack with beat noise in the address phase.
    noise = 1; ack_delay = 5;
    dc_rd_addr = 32'h0003_0040; a = dc_rd_addr;
    dc_rd_req = 1'b1;
    exp_xfer(DRD, a, BEATS, 1);
    wait_req("slow_ack_req");
    for (int i = 0; i < 6; i++) begin
      pre();
      chk("slow_req_hold", mem_req, 1);
      chk("slow_addr_hold", mem_addr, a);
      chk("slow_gnt_time", dc_rd_gnt, (i == 5));
      post();
    end
    noise = 0; ack_delay = 0;
    drain("slow_ack", 200);

    // Flush two beats into an IC burst.
    ack_delay = 1; ic_addr = 32'h0004_0080; ic_req = 1'b1;
    exp_xfer(IC, ic_addr, 2, 0);
    ic_beats_seen = 0;
    begin
      int n = 0;
      while (ic_beats_seen < 2 && n < 50) begin tick(); n++; end
      chk("xfer_flush_wait", n < 50, 1);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain("xfer_flush", 200);

    // Flush in address phase without ack: request dropped, no grant.
    ack_delay = 2; ic_addr = 32'h0005_00c0; ic_req = 1'b1;
    wait_req("addr_flush_req");
    flush = 1'b1; ic_req = 1'b0;
    pre();
    chk("addr_flush_gnt", ic_gnt, 0);
    post();
    flush = 1'b0;
    pre();
    chk("addr_flush_drop", mem_req, 0);
    post();
    drain("addr_flush", 100);

    // Flush coinciding with ack: burst runs silently, DRD waits for it.
    ack_delay = 0; ic_addr = 32'h0006_0100; ic_req = 1'b1;
    exp_xfer(IC, ic_addr, 0, 0);
    wait_req("ack_flush_req");
    flush = 1'b1; ic_req = 1'b0;
    tick();
    flush = 1'b0;
    dc_rd_addr = 32'h0006_0200; dc_rd_req = 1'b1;
    exp_xfer(DRD, dc_rd_addr, BEATS, 1);
    drain("ack_flush", 200);

    // Reset in the middle of a writeback, then a normal DRD.
    dc_wb_addr = 32'h0007_0140; dc_wb_req = 1'b1;
    exp_xfer(DWB, dc_wb_addr, 2, 0);
    wb_pops_seen = 0;
    begin
      int n = 0;
      while (wb_pops_seen < 2 && n < 50) begin tick(); n++; end
      chk("mid_rst_wait", n < 50, 1);
    end
    hold_beats = 1; rst = 1'b1;
    tick();
    rst = 1'b0; hold_beats = 0; in_burst = 0; req_wait = 0;
    pre();
    chk("mid_rst_ctrl", {mem_req, mem_we, ic_gnt, ic_data_v, ic_done, dc_rd_gnt, dc_rd_data_v,
                         dc_rd_done, dc_wb_gnt, dc_wb_pop, dc_wb_done}, 0);
    chk("mid_rst_addr", mem_addr, 0);
    post();
    chk("mid_rst_no_done", exp_q.size(), 0);
    dc_rd_addr = 32'h0008_0180; dc_rd_req = 1'b1;
    exp_xfer(DRD, dc_rd_addr, BEATS, 1);
    drain("after_rst", 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arb.md
MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Interface
REQ-001 Parameter BEATS, default 4, SHALL set the beats per cache-line transfer (32-bit beats, 16-byte line).
REQ-002 Parameter STARVE, default 2, SHALL set the maximum consecutive D-side grants while ic_req is pending before IC is forced to win.
REQ-003 Ports SHALL be: clk  in  1  clock (all logic on posedge clk); rst  in  1  reset, synchronous, active-high.
REQ-004 Ports SHALL be: ic_req in 1 fetch-miss line fill request; ic_addr in 32 line address; ic_gnt out 1 request accepted; ic_data_v out 1 read beat valid; ic_done out 1 last beat.
REQ-005 Ports SHALL be: dc_rd_req in 1; dc_rd_addr in 32; dc_rd_gnt out 1; dc_rd_data_v out 1; dc_rd_done out 1 (D-cache line fill).
REQ-006 Ports SHALL be: dc_wb_req in 1; dc_wb_addr in 32; dc_wb_data in 32 current writeback beat; dc_wb_gnt out 1; dc_wb_pop out 1 beat consumed; dc_wb_done out 1.
REQ-007 Ports SHALL be: flush in 1 pipeline redirect (interrupt/exception/branch); rd_data out 32 shared read data to all requesters.
REQ-008 Ports SHALL be: mem_req out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_ack in 1 address accepted; mem_beat in 1 one beat done; mem_rdata in 32.

Function
REQ-009 FSM SHALL have states IDLE, ADDR, XFER.
REQ-010 In IDLE with any request, winner SHALL be dc_wb > dc_rd > ic, except ic wins when starve count equals STARVE and ic_req=1; next state ADDR.
REQ-011 Owner, address and mem_we (1 only for dc_wb) SHALL be registered on IDLE->ADDR and held stable until the transfer ends.
REQ-012 In ADDR mem_req SHALL be 1 until the cycle mem_ack=1; that cycle owner's gnt SHALL pulse once and the next state SHALL be XFER with beat_cnt=0.
REQ-013 mem_beat SHALL be sampled only in XFER; in ADDR it is ignored.
REQ-014 In XFER each mem_beat SHALL increment beat_cnt and pulse owner's data_v (reads) or dc_wb_pop (writes) in that same cycle.
REQ-015 rd_data SHALL equal mem_rdata combinationally; mem_wdata SHALL equal dc_wb_data combinationally.
REQ-016 On the mem_beat with beat_cnt=BEATS-1, owner's done SHALL pulse, beat_cnt SHALL return to 0, next state IDLE; next arbitration is the following cycle (one-cycle bubble).
REQ-017 Starve count SHALL increment (saturating at STARVE) on each D-side grant with ic_req=1 and clear on every IC grant.
REQ-018 Requests deasserted after grant SHALL be ignored; the transfer completes all BEATS.
REQ-019 flush with IC owner in IDLE->ADDR or ADDR SHALL drop mem_req and return to IDLE next cycle unless mem_ack=1 that same cycle, in which case ack wins and XFER proceeds.
REQ-020 flush with IC owner in XFER SHALL let the burst complete to memory but suppress ic_data_v and ic_done for it; D-side transfers SHALL ignore flush.
REQ-021 All gnt/data_v/pop/done outputs SHALL be one-hot or zero across requesters in every cycle.

Reset
REQ-022 On rst=1 at posedge clk: state IDLE, beat_cnt=0, starve count=0, flush-suppress flag=0, owner none, mem_req=0, mem_we=0, mem_addr=0, all gnt/data_v/pop/done=0.
REQ-023 rst mid-transfer SHALL abandon the burst without any done pulse.

Structure
REQ-024 Shared package fetch_pkg SHALL hold the FSM state encoding, owner encoding (NONE/IC/DRD/DWB) and default BEATS/STARVE.
REQ-025 Priority plus starvation override SHALL be a combinational sub-module mem_arb_prio.

Verification
REQ-026 dc_wb_req, dc_rd_req, ic_req all 1 at cycle 0 -> grants in order DWB, DRD, IC (STARVE=2 forces IC third), each 4 beats, done pulses on 4th beat.
REQ-027 ic_req held, dc_rd_req re-raised after every done -> IC granted after exactly 2 DRD grants; starve count returns to 0.
REQ-028 mem_ack delayed 5 cycles -> mem_req and mem_addr stable 6 cycles, single gnt pulse on ack cycle.
REQ-029 flush 2 beats into IC burst -> mem_beat count 4 completes, ic_data_v seen only on beats 0-1, no ic_done; then IDLE.
REQ-030 flush in ADDR with IC owner, mem_ack=0 -> mem_req low next cycle, no ic_gnt; same with mem_ack=1 -> XFER entered, all data_v/done suppressed.
REQ-031 rst asserted at beat 2 of DWB -> next cycle all outputs 0, no dc_wb_done, new DRD request granted normally after.
